fetch_predict_stage: RTL and testbench

- Instruction-fetch stage that feeds the pipelined datapath's decode stage.
- Holds the 8-bit PC and reads the 16-bit instruction memory.
- Predicts branches with a direct-mapped table of 2-bit saturating counters plus a tagged branch-target buffer (BTB).
- Registers {pc, instruction, prediction} into the IF/ID register; redirects and flushes when execute reports a mispredict.

---
 rtl/fetch_predict_stage_pkg.sv | 27 ++
 rtl/fetch_predict_stage_if.sv | 36 +++
 rtl/fetch_predict_stage_bpt.sv | 58 +++++
 rtl/fetch_predict_stage.sv | 87 ++++++++
 tb/tb_fetch_predict_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_predict_stage_pkg.sv
// Shared types and constants for the fetch/predict stage: widths, 2-bit
// branch counter encoding and its saturating update.
package fetch_predict_stage_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [INSTR_W-1:0] NOP = '0;

    // Saturating step of a 2-bit direction counter.
    function automatic cnt_e cnt_next(input cnt_e c, input logic taken);
        case (c)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            default: return taken ? ST  : WT;
        endcase
    endfunction

endpackage

// File: rtl/fetch_predict_stage_if.sv
// Bundle of fetch-stage signals: instruction memory, hazard/execute feedback
// and the IF/ID register outputs toward decode.
interface fetch_predict_stage_if;
    import fetch_predict_stage_pkg::*;

    logic                 stall;
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic                 ex_update;
    logic [PC_W-1:0]      ex_pc;
    logic                 ex_taken;
    logic [PC_W-1:0]      ex_target;
    logic                 ex_mispredict;
    logic [PC_W-1:0]      ex_correct_pc;
    logic [PC_W-1:0]      pc_id;
    logic [INSTR_W-1:0]   instr_id;
    logic                 pred_taken_id;
    logic                 valid_id;
    logic                 flush_out;
    logic [15:0]          mispredict_cnt;

    modport master (
        input  stall, imem_data, ex_update, ex_pc, ex_taken, ex_target,
               ex_mispredict, ex_correct_pc,
        output imem_addr, pc_id, instr_id, pred_taken_id, valid_id,
               flush_out, mispredict_cnt
    );

    modport slave (
        output stall, imem_data, ex_update, ex_pc, ex_taken, ex_target,
               ex_mispredict, ex_correct_pc,
        input  imem_addr, pc_id, instr_id, pred_taken_id, valid_id,
               flush_out, mispredict_cnt
    );

endinterface

// File: rtl/fetch_predict_stage_bpt.sv
// Direct-mapped 2-bit counter table plus tagged BTB: combinational lookup on
// the fetch PC, synchronous training from the execute stage.
module branch_pred_table
    import fetch_predict_stage_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter cnt_e        CNT_INIT = WNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_pred,
    output logic [PC_W-1:0] lookup_tgt,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = PC_W - IDX_W;

    cnt_e             cnt_q [DEPTH];
    logic [DEPTH-1:0] btb_v_q;
    logic [TAG_W-1:0] btb_tag_q [DEPTH];
    logic [PC_W-1:0]  btb_tgt_q [DEPTH];

    logic [IDX_W-1:0] l_idx;
    logic [IDX_W-1:0] u_idx;
    logic [1:0]       l_cnt;

    assign l_idx       = lookup_pc[IDX_W-1:0];
    assign u_idx       = upd_pc[IDX_W-1:0];
    assign l_cnt       = cnt_q[l_idx];
    assign lookup_tgt  = btb_tgt_q[l_idx];
    assign lookup_pred = l_cnt[1] & btb_v_q[l_idx]
                       & (btb_tag_q[l_idx] == lookup_pc[PC_W-1:IDX_W]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_v_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[i]     <= CNT_INIT;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
            end
        end else if (upd_en) begin
            cnt_q[u_idx] <= cnt_next(cnt_q[u_idx], upd_taken);
            // Not-taken outcomes only train the counter; BTB keeps its entry.
            if (upd_taken) begin
                btb_v_q[u_idx]   <= 1'b1;
                btb_tag_q[u_idx] <= upd_pc[PC_W-1:IDX_W];
                btb_tgt_q[u_idx] <= upd_target;
            end
        end
    end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction fetch stage: PC register, predicted next-PC selection, IF/ID
// pipeline register and a saturating mispredict counter.
module fetch_predict_stage
    import fetch_predict_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int unsigned     IDX_W    = 4,
    parameter cnt_e            CNT_INIT = WNT
) (
    input logic                clk,
    input logic                reset,
    fetch_predict_stage_if.master bus
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic               pred;
    logic [PC_W-1:0]    pred_tgt;
    logic [PC_W-1:0]    pc_id_q;
    logic [INSTR_W-1:0] instr_id_q;
    logic               pred_id_q;
    logic               valid_id_q;
    logic [15:0]        mis_cnt_q;

    branch_pred_table #(
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_bpt (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc_q),
        .lookup_pred (pred),
        .lookup_tgt  (pred_tgt),
        .upd_en      (bus.ex_update),
        .upd_pc      (bus.ex_pc),
        .upd_taken   (bus.ex_taken),
        .upd_target  (bus.ex_target)
    );

    always_comb begin
        pc_d = pc_q + PC_ONE;
        if (bus.ex_mispredict) pc_d = bus.ex_correct_pc;
        else if (bus.stall)    pc_d = pc_q;
        else if (pred)         pc_d = pred_tgt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // A redirect squashes the slot even while decode is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_id_q    <= '0;
            instr_id_q <= NOP;
            pred_id_q  <= 1'b0;
            valid_id_q <= 1'b0;
        end else if (bus.ex_mispredict) begin
            pc_id_q    <= '0;
            instr_id_q <= NOP;
            pred_id_q  <= 1'b0;
            valid_id_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_id_q    <= pc_q;
            instr_id_q <= bus.imem_data;
            pred_id_q  <= pred;
            valid_id_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 mis_cnt_q <= '0;
        else if (bus.ex_mispredict && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 16'd1;
    end

    assign bus.imem_addr      = pc_q;
    assign bus.pc_id          = pc_id_q;
    assign bus.instr_id       = instr_id_q;
    assign bus.pred_taken_id  = pred_id_q;
    assign bus.valid_id       = valid_id_q;
    assign bus.flush_out      = bus.ex_mispredict;
    assign bus.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Scoreboard bench for fetch_predict_stage: a behavioural fetch/predict model
// queues expected IF/ID contents per cycle, plus directed scenario checks.
module tb_fetch_predict_stage;
    import fetch_predict_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    fetch_predict_stage_if bus ();

    fetch_predict_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = 16'hA000 + {8'h00, bus.imem_addr};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [1:0]  m_cnt [16];
    logic        m_v   [16];
    logic [3:0]  m_tag [16];
    logic [7:0]  m_tgt [16];
    logic [7:0]  m_pc, m_pc_id;
    logic [15:0] m_instr, m_mcnt;
    logic        m_pred_id, m_valid;

    typedef struct {
        logic [7:0]  pc_id;
        logic [15:0] instr;
        logic        pred;
        logic        valid;
        logic [7:0]  pc;
        logic [15:0] mcnt;
    } exp_t;

    exp_t sb [$];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i] = 2'b01;
            m_v[i]   = 1'b0;
            m_tag[i] = 4'h0;
            m_tgt[i] = 8'h00;
        end
        m_pc = 8'h00; m_pc_id = 8'h00; m_instr = 16'h0000;
        m_pred_id = 1'b0; m_valid = 1'b0; m_mcnt = 16'h0000;
    endtask

    task automatic set_ex(input logic upd, input logic [7:0] pc, input logic taken,
                          input logic [7:0] tgt, input logic mis, input logic [7:0] cpc);
        bus.ex_update = upd; bus.ex_pc = pc; bus.ex_taken = taken;
        bus.ex_target = tgt; bus.ex_mispredict = mis; bus.ex_correct_pc = cpc;
    endtask

    // One clock: model predicts post-edge state, then DUT is compared after the edge.
    task automatic tick();
        int         idx, ui;
        logic       p;
        logic [7:0] npc;
        exp_t       e;
        idx = int'(m_pc[3:0]);
        p   = m_cnt[idx][1] && m_v[idx] && (m_tag[idx] == m_pc[7:4]);
        if (bus.ex_mispredict)  npc = bus.ex_correct_pc;
        else if (bus.stall)     npc = m_pc;
        else if (p)             npc = m_tgt[idx];
        else                    npc = m_pc + 8'd1;
        if (bus.ex_mispredict) begin
            m_pc_id = 8'h00; m_instr = 16'h0000; m_pred_id = 1'b0; m_valid = 1'b0;
        end else if (!bus.stall) begin
            m_pc_id = m_pc; m_instr = 16'hA000 + {8'h00, m_pc}; m_pred_id = p; m_valid = 1'b1;
        end
        m_pc = npc;
        if (bus.ex_update) begin
            ui = int'(bus.ex_pc[3:0]);
            if (bus.ex_taken) begin
                if (m_cnt[ui] != 2'd3) m_cnt[ui] = m_cnt[ui] + 2'd1;
                m_v[ui] = 1'b1; m_tag[ui] = bus.ex_pc[7:4]; m_tgt[ui] = bus.ex_target;
            end else if (m_cnt[ui] != 2'd0) begin
                m_cnt[ui] = m_cnt[ui] - 2'd1;
            end
        end
        if (bus.ex_mispredict && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
        e.pc_id = m_pc_id; e.instr = m_instr; e.pred = m_pred_id;
        e.valid = m_valid; e.pc = m_pc; e.mcnt = m_mcnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_pc_id",   32'(bus.pc_id),          32'(e.pc_id));
        check_eq("sb_instr",   32'(bus.instr_id),       32'(e.instr));
        check_eq("sb_pred",    32'(bus.pred_taken_id),  32'(e.pred));
        check_eq("sb_valid",   32'(bus.valid_id),       32'(e.valid));
        check_eq("sb_pc",      32'(bus.imem_addr),      32'(e.pc));
        check_eq("sb_mcnt",    32'(bus.mispredict_cnt), 32'(e.mcnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.stall = 1'b0;
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(bus.valid_id),       32'h0);
        check_eq("rst_pc_id", 32'(bus.pc_id),          32'h0);
        check_eq("rst_instr", 32'(bus.instr_id),       32'h0);
        check_eq("rst_pred",  32'(bus.pred_taken_id),  32'h0);
        check_eq("rst_mcnt",  32'(bus.mispredict_cnt), 32'h0);
        check_eq("rst_pc",    32'(bus.imem_addr),      32'h00);
        reset = 1'b1;

        // Linear fetch
        tick(); check_eq("lin0_pc", 32'(bus.pc_id), 32'h00); check_eq("lin0_in", 32'(bus.instr_id), 32'hA000);
        check_eq("lin0_v", 32'(bus.valid_id), 32'h1);
        tick(); check_eq("lin1_pc", 32'(bus.pc_id), 32'h01); check_eq("lin1_in", 32'(bus.instr_id), 32'hA001);
        tick(); check_eq("lin2_pc", 32'(bus.pc_id), 32'h02); check_eq("lin2_in", 32'(bus.instr_id), 32'hA002);
        check_eq("lin2_pred", 32'(bus.pred_taken_id), 32'h0);

        // Training 05 -> 20 twice, then predicted fetch
        set_ex(1'b1, 8'h05, 1'b1, 8'h20, 1'b0, 8'h00);
        tick(); tick();
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        check_eq("trn_pc_id", 32'(bus.pc_id),         32'h05);
        check_eq("trn_pred",  32'(bus.pred_taken_id), 32'h1);
        check_eq("trn_next",  32'(bus.imem_addr),     32'h20);

        // Mispredict and flush
        set_ex(1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8'h06);
        #1 check_eq("mis_flush", 32'(bus.flush_out), 32'h1);
        tick();
        check_eq("mis_valid", 32'(bus.valid_id),       32'h0);
        check_eq("mis_pc",    32'(bus.imem_addr),      32'h06);
        check_eq("mis_cnt",   32'(bus.mispredict_cnt), 32'h1);
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        #1 check_eq("mis_flush_off", 32'(bus.flush_out), 32'h0);

        // Stall holds, mispredict overrides stall
        tick();
        bus.stall = 1'b1;
        repeat (3) tick();
        check_eq("stl_pc_id", 32'(bus.pc_id),     32'h06);
        check_eq("stl_instr", 32'(bus.instr_id),  32'hA006);
        check_eq("stl_pc",    32'(bus.imem_addr), 32'h07);
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h40);
        tick();
        check_eq("stlmis_valid", 32'(bus.valid_id),  32'h0);
        check_eq("stlmis_pc",    32'(bus.imem_addr), 32'h40);
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        bus.stall = 1'b0;

        // Tag alias: idx 5 trained for tag 0, fetch 15 must not predict
        set_ex(1'b1, 8'h05, 1'b1, 8'h20, 1'b0, 8'h00); tick();
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h15); tick();
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00); tick();
        check_eq("alias_pc_id", 32'(bus.pc_id),         32'h15);
        check_eq("alias_pred",  32'(bus.pred_taken_id), 32'h0);
        check_eq("alias_next",  32'(bus.imem_addr),     32'h16);

        // Low saturation: 4 not-taken then 1 taken leaves counter at WNT
        repeat (4) begin
            set_ex(1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00); tick();
        end
        set_ex(1'b1, 8'h05, 1'b1, 8'h20, 1'b0, 8'h00); tick();
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05); tick();
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00); tick();
        check_eq("sat_pc_id", 32'(bus.pc_id),         32'h05);
        check_eq("sat_pred",  32'(bus.pred_taken_id), 32'h0);
        check_eq("sat_next",  32'(bus.imem_addr),     32'h06);

        // PC wrap
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF); tick();
        set_ex(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00); tick();
        check_eq("wrap_pc_id", 32'(bus.pc_id),     32'hFF);
        check_eq("wrap_next",  32'(bus.imem_addr), 32'h00);

        // Async reset between edges
        #2 reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.valid_id),       32'h0);
        check_eq("arst_pc",    32'(bus.imem_addr),      32'h00);
        check_eq("arst_pc_id", 32'(bus.pc_id),          32'h0);
        check_eq("arst_mcnt",  32'(bus.mispredict_cnt), 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (7) tick();
        check_eq("post_pc_id", 32'(bus.pc_id), 32'h06);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
